// File: rtl/round_robin_mux_arbiter_pkg.sv
// rtl/round_robin_mux_arbiter_pkg.sv - shared arbiter constants, state encoding and helpers
package round_robin_mux_arbiter_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   localparam int DEF_MAX_HOLD = 8;
   localparam int HOLD_W       = 4;

   function automatic logic [3:0] onehot4(input logic [1:0] idx);
      onehot4 = 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - rotating-priority find-first over four requesters
module rr_pick4 (
   input  logic [3:0] req,
   input  logic [1:0] last,
   output logic [1:0] winner,
   output logic       any
);

   logic [1:0] w_idx;

   // Scan from the farthest slot to the nearest so the nearest hit after last wins.
   always_comb begin
      winner = last;
      w_idx  = last;
      for (int k = 4; k >= 1; k--) begin
         w_idx = last + 2'(k);
         if (req[w_idx]) begin
            winner = w_idx;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/round_robin_mux_arbiter.sv
// rtl/round_robin_mux_arbiter.sv - round-robin arbiter owning a shared 4:1 mux
module round_robin_mux_arbiter
   import round_robin_mux_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = DEF_MAX_HOLD
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic [3:0] a,
   output logic [3:0] gnt,
   output logic [1:0] s,
   output logic       y,
   output logic       valid
);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   state_t            r_state;
   logic [1:0]        r_last;
   logic [HOLD_W-1:0] r_cnt;

   logic [3:0] w_pick_req;
   logic [1:0] w_win;
   logic       w_any;
   logic       w_release;
   logic       w_new_grant;
   logic [1:0] w_sel;
   logic       w_mux_y;

   // While granted, the owner is masked so "any" means another requester is waiting.
   assign w_pick_req = (r_state == ST_GRANT) ? (req & ~onehot4(s)) : req;

   rr_pick4 u_pick (
      .req    (w_pick_req),
      .last   (r_last),
      .winner (w_win),
      .any    (w_any)
   );

   assign w_release   = (r_state == ST_GRANT) &&
                        (!req[s] || ((r_cnt == HOLD_LAST) && w_any));
   assign w_new_grant = w_any && ((r_state == ST_IDLE) || w_release);
   assign w_sel       = w_new_grant ? w_win : s;

   always_comb begin
      if (w_sel == 2'd0) begin
         w_mux_y = a[0];
      end else if (w_sel == 2'd1) begin
         w_mux_y = a[1];
      end else if (w_sel == 2'd2) begin
         w_mux_y = a[2];
      end else begin
         w_mux_y = a[3];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_last  <= 2'd3;
         r_cnt   <= '0;
         gnt     <= 4'b0000;
         s       <= 2'd0;
         y       <= 1'b0;
         valid   <= 1'b0;
      end else if (w_new_grant) begin
         r_state <= ST_GRANT;
         r_last  <= w_win;
         r_cnt   <= '0;
         gnt     <= onehot4(w_win);
         s       <= w_win;
         y       <= w_mux_y;
         valid   <= 1'b1;
      end else if (w_release) begin
         r_state <= ST_IDLE;
         gnt     <= 4'b0000;
         valid   <= 1'b0;
      end else if (r_state == ST_GRANT) begin
         if (r_cnt != HOLD_LAST) begin
            r_cnt <= r_cnt + 1'b1;
         end
         y <= w_mux_y;
      end
   end

endmodule
